// File: rtl/wb_intercon_pkg.sv
// rtl/wb_intercon_pkg.sv - shared FSM encoding and default error data for the 1xN Wishbone interconnect
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/wb_intercon_1xn_if.sv
// rtl/wb_intercon_1xn_if.sv - master-side and slave-side bus signals of the 1xN interconnect
interface wb_intercon_1xn_if #(
  parameter int WB_ADR_WIDTH  = 10,
  parameter int SLV_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH  = 32,
  parameter int NUM_SLAVES    = 3
) ();

  logic                               wb_cyc_i;
  logic                               wb_stb_i;
  logic                               wb_we_i;
  logic [WB_ADR_WIDTH-1:0]            wb_adr_i;
  logic [WB_DAT_WIDTH-1:0]            wb_dat_i;
  logic [WB_DAT_WIDTH-1:0]            wb_dat_o;
  logic                               wb_ack_o;
  logic                               wb_err_o;
  logic [NUM_SLAVES-1:0]              s_cyc_o;
  logic [NUM_SLAVES-1:0]              s_stb_o;
  logic                               s_we_o;
  logic [SLV_ADR_WIDTH-1:0]           s_adr_o;
  logic [WB_DAT_WIDTH-1:0]            s_dat_o;
  logic [NUM_SLAVES*WB_DAT_WIDTH-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]              s_ack_i;

  // Interconnect view: takes the master request and slave responses.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );

endinterface

// File: rtl/wb_timeout.sv
// rtl/wb_timeout.sv - loadable down-counter flagging a slave that has not acked within TIMEOUT cycles
module wb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loaded with TIMEOUT-1 so it reaches zero in the last permitted wait cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/wb_intercon_1xn.sv
// rtl/wb_intercon_1xn.sv - single-master N-slave Wishbone classic interconnect with error termination
module wb_intercon_1xn
  import wb_intercon_pkg::*;
#(
  parameter int                     WB_ADR_WIDTH  = 10,
  parameter int                     SLV_ADR_WIDTH = 8,
  parameter int                     WB_DAT_WIDTH  = 32,
  parameter int                     NUM_SLAVES    = 3,
  parameter int                     TIMEOUT       = 15,
  parameter logic [WB_DAT_WIDTH-1:0] ERR_DATA     = WB_DAT_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  wb_intercon_1xn_if.slave   bus
);

  localparam int SEL_W = WB_ADR_WIDTH - SLV_ADR_WIDTH;

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [NUM_SLAVES-1:0]     s_req_q, s_req_d;
  logic                      s_we_q, s_we_d;
  logic [SLV_ADR_WIDTH-1:0]  s_adr_q, s_adr_d;
  logic [WB_DAT_WIDTH-1:0]   s_dat_q, s_dat_d;
  logic [WB_DAT_WIDTH-1:0]   m_dat_q, m_dat_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;

  logic                      tmo_clr, tmo_en, tmo_expired;
  logic [SEL_W-1:0]          req_sel;
  logic                      req_mapped;
  logic                      sel_ack;
  logic [WB_DAT_WIDTH-1:0]   sel_rdata;

  assign req_sel    = bus.wb_adr_i[WB_ADR_WIDTH-1:SLV_ADR_WIDTH];
  assign req_mapped = ({1'b0, req_sel} < (SEL_W+1)'(NUM_SLAVES));

  // Only the latched slave's ack/data are looked at; others are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ack   = bus.s_ack_i[k];
        sel_rdata = bus.s_dat_i[k*WB_DAT_WIDTH +: WB_DAT_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    s_req_d = s_req_q;
    s_we_d  = s_we_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    m_dat_d = m_dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          sel_d   = req_sel;
          s_we_d  = bus.wb_we_i;
          s_adr_d = bus.wb_adr_i[SLV_ADR_WIDTH-1:0];
          s_dat_d = bus.wb_dat_i;
          if (req_mapped) begin
            state_d = ST_WAIT;
            s_req_d = NUM_SLAVES'(1) << req_sel;
            tmo_clr = 1'b1;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            m_dat_d = ERR_DATA;
          end
        end
      end
      ST_WAIT: begin
        tmo_en = 1'b1;
        if (!bus.wb_cyc_i) begin
          state_d = ST_IDLE;
          s_req_d = '0;
        end else if (sel_ack) begin
          state_d = ST_RESP;
          s_req_d = '0;
          ack_d   = 1'b1;
          m_dat_d = sel_rdata;
        end else if (tmo_expired) begin
          state_d = ST_RESP;
          s_req_d = '0;
          err_d   = 1'b1;
          m_dat_d = ERR_DATA;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_req_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      s_req_q <= '0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      m_dat_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      s_req_q <= s_req_d;
      s_we_q  <= s_we_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      m_dat_q <= m_dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  assign bus.s_cyc_o  = s_req_q;
  assign bus.s_stb_o  = s_req_q;
  assign bus.s_we_o   = s_we_q;
  assign bus.s_adr_o  = s_adr_q;
  assign bus.s_dat_o  = s_dat_q;
  assign bus.wb_dat_o = m_dat_q;
  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;

endmodule

// File: tb/tb_wb_intercon_1xn.sv
// tb/tb_wb_intercon_1xn.sv - directed and randomized checks of wb_intercon_1xn against a transaction-level model
module tb_wb_intercon_1xn;

  localparam int AW  = 10;
  localparam int SAW = 8;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int TO  = 15;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_intercon_1xn_if #(
    .WB_ADR_WIDTH (AW),
    .SLV_ADR_WIDTH(SAW),
    .WB_DAT_WIDTH (DW),
    .NUM_SLAVES   (NS)
  ) bus ();

  wb_intercon_1xn #(
    .WB_ADR_WIDTH (AW),
    .SLV_ADR_WIDTH(SAW),
    .WB_DAT_WIDTH (DW),
    .NUM_SLAVES   (NS),
    .TIMEOUT      (TO),
    .ERR_DATA     (ERRD)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master transfer. ack_cyc: wait-cycle index in which the selected slave
  // holds ack (-1 = never); wrong_cyc: cycle in which slave 0 acks spuriously;
  // abort_cyc / rst_cyc: cycle in which cyc is dropped / reset is pulsed.
  task automatic run_txn(input string tag, input logic [AW-1:0] adr, input logic we,
                         input logic [DW-1:0] wdat, input logic [DW-1:0] rdat,
                         input int ack_cyc, input int wrong_cyc, input int abort_cyc,
                         input int rst_cyc);
    int sel = int'(adr[AW-1:SAW]);
    bit mapped = (sel < NS);
    int exp_kind, exp_edge, exp_stb, kill;
    logic [DW-1:0] exp_dat;
    int n_ack = 0, n_err = 0, resp_edge = -1, stb_cyc = 0;
    logic [DW-1:0] resp_dat = '0;
    bit stb_bad = 0, shared_bad = 0, both = 0;
    logic [NS*DW-1:0] sd;
    logic [NS-1:0] sa;
    logic [NS-1:0] onehot;

    onehot = '0;
    if (mapped) onehot[sel] = 1'b1;
    if (!mapped) begin
      exp_kind = 2; exp_edge = 0; exp_dat = ERRD;
    end else if (ack_cyc >= 0 && ack_cyc <= TO - 1) begin
      exp_kind = 1; exp_edge = ack_cyc + 1; exp_dat = rdat;
    end else begin
      exp_kind = 2; exp_edge = TO; exp_dat = ERRD;
    end
    exp_stb = mapped ? exp_edge : 0;
    kill = (abort_cyc >= 0) ? abort_cyc : rst_cyc;
    if (mapped && kill >= 0 && kill < exp_edge) begin
      exp_kind = 0;
      exp_stb  = kill + 1;
    end

    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = wdat;
    @(posedge clk); #1;
    for (int e = 0; e < TO + 4; e++) begin
      if (bus.wb_ack_o === 1'b1) begin
        n_ack++;
        if (resp_edge < 0) begin resp_edge = e; resp_dat = bus.wb_dat_o; end
      end
      if (bus.wb_err_o === 1'b1) begin
        n_err++;
        if (resp_edge < 0) begin resp_edge = e; resp_dat = bus.wb_dat_o; end
      end
      if (bus.wb_ack_o === 1'b1 && bus.wb_err_o === 1'b1) both = 1;
      if (bus.s_stb_o !== '0) begin
        stb_cyc++;
        if (bus.s_stb_o !== onehot || bus.s_cyc_o !== onehot) stb_bad = 1;
        if (bus.s_adr_o !== adr[SAW-1:0] || bus.s_we_o !== we || bus.s_dat_o !== wdat)
          shared_bad = 1;
      end
      if (bus.wb_ack_o === 1'b1 || bus.wb_err_o === 1'b1) begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      end
      sd = {$urandom, $urandom, $urandom};
      sa = '0;
      if (mapped && e == ack_cyc) begin
        sa[sel] = 1'b1;
        sd[sel*DW +: DW] = rdat;
      end
      if (e == wrong_cyc) sa[0] = 1'b1;
      bus.s_dat_i = sd;
      bus.s_ack_i = sa;
      if (e == abort_cyc) begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      end
      if (e == rst_cyc) begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_stb"}, 32'(bus.s_stb_o), 32'd0);
        chk({tag, "_rst_ack_err"}, {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
        #2 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.s_ack_i = '0;

    chk({tag, "_nack"}, 32'(n_ack), (exp_kind == 1) ? 32'd1 : 32'd0);
    chk({tag, "_nerr"}, 32'(n_err), (exp_kind == 2) ? 32'd1 : 32'd0);
    chk({tag, "_stbcyc"}, 32'(stb_cyc), 32'(exp_stb));
    chk({tag, "_stbsel"}, 32'(stb_bad), 32'd0);
    chk({tag, "_shared"}, 32'(shared_bad), 32'd0);
    chk({tag, "_ackerr"}, 32'(both), 32'd0);
    if (exp_kind != 0) begin
      chk({tag, "_edge"}, 32'(resp_edge), 32'(exp_edge));
      chk({tag, "_dat"}, resp_dat, exp_dat);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    int ac, wc;

    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
    bus.s_dat_i  = '0;   bus.s_ack_i  = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {29'd0, bus.wb_ack_o, bus.wb_err_o, bus.s_we_o}, 32'd0);
    chk("reset_wbdat", bus.wb_dat_o, 32'd0);
    chk("reset_stb", {26'd0, bus.s_cyc_o, bus.s_stb_o}, 32'd0);
    chk("reset_sadr", 32'(bus.s_adr_o), 32'd0);
    chk("reset_sdat", bus.s_dat_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("rd_s0",    10'h005, 1'b0, 32'h0,        32'h12345678, 1,  -1, -1, -1);
    run_txn("wr_s2",    10'h2A0, 1'b1, 32'hCAFEF00D, 32'h0BADF00D, 1,  -1, -1, -1);
    run_txn("unmapped", 10'h3FF, 1'b0, 32'h1,        32'h2,        1,  -1, -1, -1);
    run_txn("tmo_s1",   10'h177, 1'b0, 32'h3,        32'h4,        -1, -1, -1, -1);
    run_txn("ack_c15",  10'h111, 1'b0, 32'h5,        32'hA5A5A5A5, TO - 1, -1, -1, -1);
    run_txn("abort",    10'h010, 1'b0, 32'h6,        32'h7,        -1, -1, 3,  -1);
    run_txn("rd_after_abort", 10'h005, 1'b0, 32'h0,  32'h87654321, 1,  -1, -1, -1);
    run_txn("rst_wait", 10'h020, 1'b1, 32'h8,        32'h9,        -1, -1, -1, 4);
    run_txn("rd_after_rst", 10'h005, 1'b0, 32'h0,    32'h13572468, 1,  -1, -1, -1);
    run_txn("wrong_ack", 10'h1C3, 1'b0, 32'hA,       32'h5EED5EED, 5,  1,  -1, -1);

    // Held request on an unmapped address: accepted again right after RESP.
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 10'h3C0;
    @(posedge clk); #1;
    chk("b2b_err0", 32'(bus.wb_err_o), 32'd1);
    @(posedge clk); #1;
    chk("b2b_err1", 32'(bus.wb_err_o), 32'd0);
    @(posedge clk); #1;
    chk("b2b_err2", 32'(bus.wb_err_o), 32'd1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom_range(0, (1 << AW) - 1));
      ac = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 17));
      wc = (ra[AW-1:SAW] != 2'd0) ? int'($urandom_range(0, 17)) : -1;
      run_txn($sformatf("rnd%0d", i), ra, 1'($urandom_range(0, 1)), $urandom, $urandom,
              ac, wc, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
